// File: rtl/key_event.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | key_event : click / double-click / long-press / auto-repeat classifier     |
// | Optional build macro KEY_REPEAT_EN enables the rep_o auto-repeat pulses.   |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module key_event #(
  parameter int LONG_TICKS   = 200,
  parameter int DCLICK_GAP   = 60,
  parameter int REPEAT_TICKS = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pressed_i,
  output logic click_o,
  output logic dclick_o,
  output logic long_o,
  output logic rep_o,
  output logic busy_o
);

  localparam bit c_params_ok = (LONG_TICKS   >= 2) && (LONG_TICKS   <= 255) &&
                               (DCLICK_GAP   >= 2) && (DCLICK_GAP   <= 255) &&
                               (REPEAT_TICKS >= 2) && (REPEAT_TICKS <= 255);

  generate
    if (!c_params_ok) begin : g_param_err
      $error("key_event: tick parameters must lie in 2..255");
    end
  endgenerate

  localparam logic [7:0] c_long_ticks = 8'(LONG_TICKS);
  localparam logic [7:0] c_dclick_gap = 8'(DCLICK_GAP);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    WAIT2  = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] w_cnt_inc;
  logic       click_q, click_d;
  logic       dclick_q, dclick_d;
  logic       long_q, long_d;
  logic       busy_q, busy_d;

`ifdef KEY_REPEAT_EN
  localparam logic [7:0] c_repeat_ticks = 8'(REPEAT_TICKS);
  logic rep_q, rep_d;
`endif

  // Saturating increment: the counter never wraps back to a small value.
  assign w_cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    click_d  = 1'b0;
    dclick_d = 1'b0;
    long_d   = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pressed_i) begin
          state_d = PRESS1;
          cnt_d   = 8'd1;
        end
      end
      PRESS1: begin
        if (!pressed_i) begin
          state_d = WAIT2;
          cnt_d   = 8'd1;
        end else if (w_cnt_inc == c_long_ticks) begin
          state_d = LONG;
          cnt_d   = 8'd0;
          long_d  = 1'b1;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      WAIT2: begin
        // A high edge breaks the low run, so the press always wins here.
        if (pressed_i) begin
          state_d = PRESS2;
          cnt_d   = 8'd0;
        end else if (w_cnt_inc == c_dclick_gap) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          click_d = 1'b1;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      PRESS2: begin
        if (!pressed_i) begin
          state_d  = IDLE;
          cnt_d    = 8'd0;
          dclick_d = 1'b1;
        end else begin
          cnt_d = w_cnt_inc;
        end
      end
      LONG: begin
        if (!pressed_i) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else begin
`ifdef KEY_REPEAT_EN
          if (w_cnt_inc == c_repeat_ticks) begin
            cnt_d = 8'd0;
            rep_d = 1'b1;
          end else begin
            cnt_d = w_cnt_inc;
          end
`else
          cnt_d = cnt_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      click_q  <= 1'b0;
      dclick_q <= 1'b0;
      long_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      click_q  <= click_d;
      dclick_q <= dclick_d;
      long_q   <= long_d;
      busy_q   <= busy_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rep_q <= 1'b0;
    end else begin
      rep_q <= rep_d;
    end
  end
  assign rep_o = rep_q;
`else
  assign rep_o = 1'b0;
`endif

  assign click_o  = click_q;
  assign dclick_o = dclick_q;
  assign long_o   = long_q;
  assign busy_o   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_key_event.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_key_event : scoreboard bench for key_event (default tick parameters)    |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module tb_key_event;

  localparam int K_CLICK  = 0;
  localparam int K_DCLICK = 1;
  localparam int K_LONG   = 2;
  localparam int K_REP    = 3;

`ifdef KEY_REPEAT_EN
  localparam bit c_rep_en = 1'b1;
`else
  localparam bit c_rep_en = 1'b0;
`endif

  logic clk;
  logic rst;
  logic pressed;
  logic click_o, dclick_o, long_o, rep_o, busy_o;

  key_event #(
    .LONG_TICKS  (200),
    .DCLICK_GAP  (60),
    .REPEAT_TICKS(20)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .pressed_i(pressed),
    .click_o  (click_o),
    .dclick_o (dclick_o),
    .long_o   (long_o),
    .rep_o    (rep_o),
    .busy_o   (busy_o)
  );

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  ev_t  exp_q[$];
  int   cyc;
  int   tests;
  int   fails;
  int   mon_n;
  logic [3:0] mon_v;
  ev_t  mon_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    tests = tests + 1;
    if (act != expv) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic push(input int k);
    ev_t e;
    e.kind = k;
    e.cyc  = cyc;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic p, input logic r);
    pressed = p;
    rst     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic p, input int n);
    repeat (n) step(p, 1'b0);
  endtask

  // Monitor: every pulse the DUT presents must match the head of the queue.
  always @(negedge clk) begin
    mon_v = {rep_o === 1'b1, long_o === 1'b1, dclick_o === 1'b1, click_o === 1'b1};
    mon_n = int'(mon_v[0]) + int'(mon_v[1]) + int'(mon_v[2]) + int'(mon_v[3]);
    if (mon_n > 0) chk("pulse_onehot", mon_n, 1);
    for (int k = 0; k < 4; k++) begin
      if (mon_v[k]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse_kind", k, -1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pulse_kind", k, mon_e.kind);
          chk("pulse_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    cyc     = 0;
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    pressed = 1'b1;

    // Reset held for 3 cycles with the key pressed: all outputs quiet.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      chk("reset_outputs", int'({click_o, dclick_o, long_o, rep_o, busy_o}), 0);
    end
    // Still pressed after reset: a fresh press, long after 200 edges.
    for (int i = 1; i <= 200; i++) begin
      step(1'b1, 1'b0);
      if (i == 1) chk("busy_after_reset_press", int'(busy_o), 1);
      if (i == 200) push(K_LONG);
    end
    step(1'b0, 1'b0);
    chk("busy_after_long_release", int'(busy_o), 0);
    run(1'b0, 70);

    // Single click: 10 pressed, click after the 60th low edge.
    run(1'b1, 10);
    for (int i = 1; i <= 60; i++) begin
      step(1'b0, 1'b0);
      if (i == 59) chk("busy_in_wait2", int'(busy_o), 1);
      if (i == 60) push(K_CLICK);
    end
    step(1'b0, 1'b0);
    chk("busy_after_click", int'(busy_o), 0);
    run(1'b0, 5);

    // Double click: 10 / 30 / 10 then release.
    run(1'b1, 10);
    run(1'b0, 30);
    run(1'b1, 10);
    step(1'b0, 1'b0);
    push(K_DCLICK);
    run(1'b0, 70);
    chk("busy_after_dclick", int'(busy_o), 0);

    // Long and repeat: hold 260 edges, release gives nothing.
    for (int i = 1; i <= 260; i++) begin
      step(1'b1, 1'b0);
      if (i == 200) push(K_LONG);
      if (c_rep_en && (i == 220 || i == 240 || i == 260)) push(K_REP);
    end
    run(1'b0, 70);
    chk("busy_after_repeat_release", int'(busy_o), 0);

    // 199 edges: no long press, then a click.
    run(1'b1, 199);
    for (int i = 1; i <= 60; i++) begin
      step(1'b0, 1'b0);
      if (i == 60) push(K_CLICK);
    end
    run(1'b0, 3);

    // Gap of 59 lows then a press: double-click path.
    run(1'b1, 10);
    run(1'b0, 59);
    run(1'b1, 5);
    step(1'b0, 1'b0);
    push(K_DCLICK);
    run(1'b0, 70);

    // Gap of exactly 60 lows: click, then the next press starts a new PRESS1.
    run(1'b1, 10);
    for (int i = 1; i <= 60; i++) begin
      step(1'b0, 1'b0);
      if (i == 60) push(K_CLICK);
    end
    step(1'b1, 1'b0);
    chk("busy_new_press1", int'(busy_o), 1);
    run(1'b1, 4);
    for (int i = 1; i <= 60; i++) begin
      step(1'b0, 1'b0);
      if (i == 60) push(K_CLICK);
    end
    run(1'b0, 3);

    // Reset on edge 230 of a hold: no more repeats, new long 200 edges later.
    for (int i = 1; i <= 230; i++) begin
      if (i == 230) begin
        step(1'b1, 1'b1);
        chk("reset_mid_long_outputs", int'({click_o, dclick_o, long_o, rep_o, busy_o}), 0);
      end else begin
        step(1'b1, 1'b0);
        if (i == 200) push(K_LONG);
        if (c_rep_en && i == 220) push(K_REP);
      end
    end
    for (int i = 1; i <= 215; i++) begin
      step(1'b1, 1'b0);
      if (i == 200) push(K_LONG);
    end
    run(1'b0, 5);
    chk("busy_final", int'(busy_o), 0);

    chk("scoreboard_leftover", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_event.md
KEY_EVENT -- requirements
Module: key_event

Interface
REQ-001 Parameter LONG_TICKS, default 200, consecutive pressed clock edges for a long press (1 s at the 5 ms clock).
REQ-002 Parameter DCLICK_GAP, default 60, maximum released clock edges between presses of a double click (300 ms).
REQ-003 Parameter REPEAT_TICKS, default 20, held clock edges between auto-repeat pulses (100 ms).
REQ-004 clk_i  input  1  single clock, 5 ms period, same clock as the debouncer.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 pressed_i  input  1  debounced key level from the debounce stage, high = pressed.
REQ-007 click_o  output  1  one-cycle pulse, single short click.
REQ-008 dclick_o  output  1  one-cycle pulse, double click.
REQ-009 long_o  output  1  one-cycle pulse, long press reached.
REQ-010 rep_o  output  1  one-cycle pulse, auto-repeat while long-held.
REQ-011 busy_o  output  1  level, high whenever the FSM is not in IDLE.

Function
REQ-012 The block SHALL use one 8-bit edge counter; all parameters SHALL lie in 2..255; the counter SHALL saturate at 255 and never wrap.
REQ-013 The FSM SHALL have exactly the states IDLE, PRESS1, WAIT2, PRESS2 and LONG; all outputs SHALL be registered.
REQ-014 IDLE: an edge sampling pressed_i=1 SHALL enter PRESS1 with the count set to 1; otherwise the FSM SHALL stay in IDLE.
REQ-015 PRESS1: each edge with pressed_i=1 SHALL increment the count; on the LONG_TICKS-th consecutive pressed edge the FSM SHALL enter LONG and assert long_o for the following cycle.
REQ-016 PRESS1: an edge with pressed_i=0 before LONG_TICKS SHALL enter WAIT2 with the count set to 1; that release edge counts as the first low edge.
REQ-017 WAIT2: an edge with pressed_i=1 SHALL enter PRESS2; on the DCLICK_GAP-th consecutive low edge the FSM SHALL enter IDLE and assert click_o for one cycle.
REQ-018 PRESS2: the edge sampling pressed_i=0 SHALL enter IDLE and assert dclick_o for one cycle; holding in PRESS2 SHALL produce no long_o or rep_o.
REQ-019 LONG: while pressed_i=1, rep_o SHALL pulse after every REPEAT_TICKS further pressed edges, with the count restarting after each pulse; pressed_i=0 SHALL enter IDLE with no pulse.
REQ-020 At most one of click_o, dclick_o, long_o and rep_o SHALL be high in any cycle.
REQ-021 A press sampled on the same edge that would complete the DCLICK_GAP count is impossible by construction, because a high edge breaks the low run; the press SHALL win and the FSM SHALL enter PRESS2.

Reset
REQ-022 While rst_i is high at a clock edge, the FSM SHALL go to IDLE, the count SHALL clear, and all outputs SHALL be 0 on the next cycle.
REQ-023 Reset mid-operation SHALL discard the pending event with no pulse emitted.
REQ-024 If pressed_i is high on the first edge after reset, it SHALL be treated as a new press entering PRESS1.

Configuration
REQ-025 Macro KEY_REPEAT_EN defined: the LONG-state repeat counter and rep_o pulses SHALL be implemented per REQ-019.
REQ-026 Macro KEY_REPEAT_EN undefined: the repeat logic SHALL be omitted, rep_o SHALL be tied to 0, the port SHALL remain present, and all other behaviour SHALL be unchanged.

Verification
REQ-027 Reset: rst_i high for 3 cycles with pressed_i=1 held -> all outputs 0 during reset; after reset, long_o asserts after the 200th pressed edge.
REQ-028 Single click: press for 10 edges, then release -> click_o high exactly one cycle after the 60th low edge; no other pulses; busy_o returns to 0.
REQ-029 Double click: press 10, release 30, press 10, release -> dclick_o one cycle after the second release edge; click_o stays 0 throughout.
REQ-030 Long and repeat: hold for 260 edges -> long_o after edge 200 and rep_o after edges 220, 240 and 260; release gives no click_o; with KEY_REPEAT_EN undefined, rep_o stays 0.
REQ-031 Boundaries: hold 199 edges then release -> no long_o, then click_o; a gap of 59 lows then a press -> PRESS2 path; a gap of exactly 60 lows -> click_o, and a press on the next edge enters PRESS1.
REQ-032 Reset mid-LONG: one rst_i cycle at edge 230 of a hold -> no further rep_o; with pressed_i still high, the FSM re-enters PRESS1 and long_o fires 200 edges later.
